// File: rtl/sme_dom_sched.sv
// rtl/sme_dom_sched.sv - two-requester scheduler feeding one masked (DOM) AND gadget
module sme_dom_sched #(
    parameter int D = 3,
    parameter int N = 32,
    localparam int RMAX = D + D * (D - 1) / 2
) (
    input  logic              g_clk,
    input  logic              g_reset,
    output logic              g_clk_req,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [D*N-1:0]    req0_rs1,
    input  logic [D*N-1:0]    req0_rs2,
    input  logic [D*N-1:0]    req1_rs1,
    input  logic [D*N-1:0]    req1_rs2,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [D*N-1:0]    rsp_rd,
    output logic              rng_req,
    input  logic              rng_ack,
    input  logic [RMAX*N-1:0] rng_data,
    output logic              and_en,
    output logic [D*N-1:0]    and_rs1,
    output logic [D*N-1:0]    and_rs2,
    output logic [RMAX*N-1:0] and_rng,
    input  logic [D*N-1:0]    and_rd
);

    typedef enum logic [1:0] {IDLE, WAIT_RNG, EXEC, RESP} state_t;

    state_t              state_q;
    logic                rr_q;
    logic                id_q;
    logic [D*N-1:0]      rs1_q;
    logic [D*N-1:0]      rs2_q;
    logic [D*N-1:0]      res_q;
    logic [RMAX*N-1:0]   rng_q;
    logic                grant0;
    logic                grant1;
    logic                rsp_hs;
    logic                exec;

    // rr_q names the requester that wins when both are valid
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (rr_q) begin
                grant1 = req1_valid;
                grant0 = req0_valid & ~req1_valid;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid & ~req0_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_hs     = (state_q == RESP) && (id_q ? rsp1_ready : rsp0_ready);
    assign exec       = (state_q == EXEC);

    // Shares reach the gadget only during EXEC so its inputs stay quiet otherwise
    assign and_en     = exec;
    assign and_rs1    = exec ? rs1_q : '0;
    assign and_rs2    = exec ? rs2_q : '0;
    assign and_rng    = exec ? rng_q : '0;

    assign rng_req    = (state_q == WAIT_RNG);
    assign rsp0_valid = (state_q == RESP) && !id_q;
    assign rsp1_valid = (state_q == RESP) && id_q;
    assign rsp_rd     = (state_q == RESP) ? res_q : '0;
    assign g_clk_req  = !g_reset && ((state_q != IDLE) || req0_valid || req1_valid);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            rng_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        rs1_q   <= grant1 ? req1_rs1 : req0_rs1;
                        rs2_q   <= grant1 ? req1_rs2 : req0_rs2;
                        id_q    <= grant1;
                        rr_q    <= grant0;
                        state_q <= WAIT_RNG;
                    end
                end
                WAIT_RNG: begin
                    if (rng_ack) begin
                        rng_q   <= rng_data;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= and_rd;
                    state_q <= RESP;
                end
                RESP: begin
                    // Scrub every secret-bearing register as the result leaves
                    if (rsp_hs) begin
                        rs1_q   <= '0;
                        rs2_q   <= '0;
                        rng_q   <= '0;
                        res_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sme_dom_sched.md
SME_DOM_SCHED -- requirements
Module: sme_dom_sched

Interface
- REQ-001: Parameters SHALL be:
  - D, 3, number of shares.
  - N, 32, share width in bits.
  - RMAX, D+D*(D-1)/2, number of guard-randomness words (derived; not overridable).
- REQ-002: Ports SHALL be (width; meaning):
  - g_clk, input, 1; sole clock, posedge.
  - g_reset, input, 1; asynchronous, active-high reset.
  - g_clk_req, output, 1; clock request.
  - req0_valid / req1_valid, input, 1 each; requester operation valid.
  - req0_ready / req1_ready, output, 1 each; request accepted.
  - req0_rs1, req0_rs2, req1_rs1, req1_rs2, input, D*N each; shared operands, share d at bits [d*N+N-1:d*N].
  - rsp0_valid / rsp1_valid, output, 1 each; result valid.
  - rsp0_ready / rsp1_ready, input, 1 each; result consumed.
  - rsp_rd, output, D*N; result shares, shared by both responders.
  - rng_req, output, 1; fresh randomness request.
  - rng_ack, input, 1; rng_data valid.
  - rng_data, input, RMAX*N; guard randomness.
  - and_en, output, 1; enable to the DOM AND gadget (negedge-capturing variant).
  - and_rs1, and_rs2, output, D*N each; gadget operands.
  - and_rng, output, RMAX*N; gadget randomness.
  - and_rd, input, D*N; gadget result shares.

Function
- REQ-003: FSM states SHALL be IDLE, WAIT_RNG, EXEC, RESP; no other reachable states.
- REQ-004: In IDLE the arbiter SHALL grant by round-robin over valid requesters; after reset, priority goes to requester 0; after each grant, priority goes to the other requester.
- REQ-005: In IDLE, reqX_ready SHALL be asserted combinationally only for the granted requester; no ready outside IDLE; at most one ready per cycle.
- REQ-006: On reqX_valid && reqX_ready, the block SHALL latch rs1/rs2 and the requester ID, and move to WAIT_RNG.
- REQ-007: In WAIT_RNG, rng_req SHALL be held high until rng_ack; on rng_ack, rng_data SHALL be latched and the FSM SHALL move to EXEC the next cycle.
- REQ-008: EXEC SHALL last exactly one cycle, with and_en=1 and and_rs1/and_rs2/and_rng driven from the latched registers.
- REQ-009: Outside EXEC, and_rs1, and_rs2 and and_rng SHALL be all-zero and and_en=0, so the gadget inputs never toggle.
- REQ-010: At the posedge ending EXEC, and_rd SHALL be captured into the result register and the FSM SHALL move to RESP.
- REQ-011: In RESP, rspX_valid SHALL be high only for the latched requester ID, and rsp_rd SHALL equal the result register; rsp_rd SHALL be zero whenever no rsp valid is high.
- REQ-012: On rspX_valid && rspX_ready, the FSM SHALL return to IDLE and zero the operand, randomness and result registers at that same edge.
- REQ-013: Each randomness word SHALL be used for exactly one EXEC; a rng_ack outside WAIT_RNG SHALL be ignored.
- REQ-014: Minimum latency SHALL be 3 cycles from accept to rsp valid (accept, WAIT_RNG with same-cycle ack, EXEC, then RESP); each cycle without rng_ack in WAIT_RNG adds one cycle.
- REQ-015: A new request SHALL be accepted no earlier than the cycle after the response handshake; there is no pipelining.
- REQ-016: g_clk_req SHALL be high when state != IDLE or either reqX_valid is high.
- REQ-017: Requesters SHALL hold valid and operands stable until ready; the block SHALL not check this.

Reset
- REQ-018: g_reset high SHALL asynchronously force:
  - state to IDLE and the round-robin pointer to requester 0;
  - all data registers to zero;
  - all outputs to zero, except reqX_ready, which follows REQ-005.
- REQ-019: Reset during any state SHALL abandon the operation with no response; the first post-reset rng_ack SHALL not be consumed unless a request was accepted.

Verification
- REQ-020: Single op, D=3, N=32:
  - stimulus: req0 operands unmasking to 0xF0F0F0F0 and 0xFF00FF00, random shares, rng_ack immediate;
  - response: rsp0_valid 3 cycles after accept, and the XOR of the rsp_rd shares = 0xF000F000.
- REQ-021: Contention: both reqX_valid held high for 4 ops -> grant order 0,1,0,1.
- REQ-022: rng_ack delayed 5 cycles -> rng_req held high 6 cycles, and_en high exactly 1 cycle, latency 8.
- REQ-023: rsp0_ready low 10 cycles -> rsp_rd stable throughout; req1 not accepted until the cycle after the handshake.
- REQ-024: g_reset asserted in EXEC -> and_en=0 immediately, no rsp valid, next op correct with no stale randomness.
- REQ-025: Leakage checks:
  - and_rs1/and_rs2/and_rng are zero in every non-EXEC cycle;
  - internal registers are zero after each response handshake.
